// File: rtl/dual_slope_seq.sv
// Dual-slope conversion sequencer: discharge, autozero, fixed integrate, timed de-integrate, autorange.
// Latency: outputs registered; status inputs pass 2-flop synchronisers whose delay is part of the count.
// Backpressure: none; start_i is level-sampled in IDLE only and each result is a one-cycle valid_o strobe.
module dual_slope_seq #(
  parameter int T_RST       = 16,
  parameter int T_AZ        = 1024,
  parameter int T_INT       = 2000,
  parameter int CNT_W       = 12,
  parameter int N_DEINT_MAX = 4095,
  parameter int R_LO        = 400,
  parameter int RANGE_MAX   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             autorange_en_i,
  input  logic [2:0]       mode_sel_i,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic [3:0]       afe_sel_o,
  output logic             afe_reset_o,
  output logic             ref_sign_o,
  output logic [4:0]       range_sel_o,
  output logic [2:0]       mode_sel_o,
  output logic [CNT_W-1:0] result_o,
  output logic             sign_o,
  output logic             ovr_o,
  output logic             valid_o,
  output logic             busy_o
);

  // The phase counter serves every timed state, so it is sized for the longest one.
  localparam int PH_M1  = (T_RST > T_AZ) ? T_RST : T_AZ;
  localparam int PH_M2  = (PH_M1 > T_INT) ? PH_M1 : T_INT;
  localparam int PH_MAX = (PH_M2 > N_DEINT_MAX) ? PH_M2 : N_DEINT_MAX;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]  RST_LAST   = PH_W'(T_RST - 1);
  localparam logic [PH_W-1:0]  AZ_LAST    = PH_W'(T_AZ - 1);
  localparam logic [PH_W-1:0]  INT_LAST   = PH_W'(T_INT - 1);
  localparam logic [PH_W-1:0]  DEINT_LAST = PH_W'(N_DEINT_MAX);
  localparam logic [CNT_W-1:0] R_LO_V     = CNT_W'(R_LO);
  localparam logic [4:0]       RANGE_TOP  = 5'(RANGE_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_REF, S_RST, S_AZ, S_INT, S_DEINT, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   ph_cnt;
  logic              pol, pol_nxt;
  logic [1:0]        comp_sync, sat_hi_sync, sat_lo_sync, ref_ok_sync;
  logic              comp_s, sat_s, ref_ok_s;
  logic              counting;

  logic [2:0]        mode_nxt;
  logic [CNT_W-1:0]  result_nxt;
  logic              sign_nxt, ovr_nxt;
  logic [4:0]        range_nxt;
  logic [3:0]        sel_nxt;
  logic              afe_reset_nxt, ref_sign_nxt, valid_nxt, busy_nxt;

  // Two-flop synchronisers for the analog-side status lines.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      comp_sync   <= '0;
      sat_hi_sync <= '0;
      sat_lo_sync <= '0;
      ref_ok_sync <= '0;
    end else begin
      comp_sync   <= {comp_sync[0], comp_i};
      sat_hi_sync <= {sat_hi_sync[0], sat_hi_i};
      sat_lo_sync <= {sat_lo_sync[0], sat_lo_i};
      ref_ok_sync <= {ref_ok_sync[0], ref_ok_i};
    end
  end

  assign comp_s   = comp_sync[1];
  assign sat_s    = sat_hi_sync[1] | sat_lo_sync[1];
  assign ref_ok_s = ref_ok_sync[1];
  assign counting = state inside {S_RST, S_AZ, S_INT, S_DEINT};

  // State, latched polarity and phase counter; the counter restarts on every state change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      pol    <= 1'b0;
      ph_cnt <= '0;
    end else begin
      state <= state_nxt;
      pol   <= pol_nxt;
      if (state_nxt != state) ph_cnt <= '0;
      else if (counting)      ph_cnt <= ph_cnt + PH_W'(1);
    end
  end

  // Next-state, result capture and autorange decisions.
  always_comb begin
    state_nxt  = state;
    pol_nxt    = pol;
    mode_nxt   = mode_sel_o;
    result_nxt = result_o;
    sign_nxt   = sign_o;
    ovr_nxt    = ovr_o;
    range_nxt  = range_sel_o;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          mode_nxt  = mode_sel_i;
          state_nxt = S_WAIT_REF;
        end
      end
      S_WAIT_REF: begin
        if (ref_ok_s) state_nxt = S_RST;
      end
      S_RST: begin
        if (!ref_ok_s)               state_nxt = S_WAIT_REF;
        else if (ph_cnt == RST_LAST) state_nxt = S_AZ;
      end
      S_AZ: begin
        if (!ref_ok_s)              state_nxt = S_WAIT_REF;
        else if (ph_cnt == AZ_LAST) state_nxt = S_INT;
      end
      S_INT: begin
        if (!ref_ok_s) begin
          state_nxt = S_WAIT_REF;
        end else if (sat_s) begin
          // Rail hit while integrating: polarity is whatever the comparator shows now.
          pol_nxt    = comp_s;
          result_nxt = '1;
          ovr_nxt    = 1'b1;
          sign_nxt   = ~comp_s;
          state_nxt  = S_DONE;
        end else if (ph_cnt == INT_LAST) begin
          pol_nxt   = comp_s;
          state_nxt = S_DEINT;
        end
      end
      S_DEINT: begin
        if (!ref_ok_s) begin
          state_nxt = S_WAIT_REF;
        end else if (sat_s) begin
          result_nxt = '1;
          ovr_nxt    = 1'b1;
          sign_nxt   = ~pol;
          state_nxt  = S_DONE;
        end else if (comp_s != pol) begin
          // Zero crossing seen: the count so far is the conversion result.
          result_nxt = CNT_W'(ph_cnt);
          ovr_nxt    = 1'b0;
          sign_nxt   = ~pol;
          state_nxt  = S_DONE;
        end else if (ph_cnt == DEINT_LAST) begin
          result_nxt = '1;
          ovr_nxt    = 1'b1;
          sign_nxt   = ~pol;
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = cont_i ? S_RST : S_IDLE;
        if (autorange_en_i) begin
          if (ovr_o && (range_sel_o < RANGE_TOP))
            range_nxt = range_sel_o + 5'd1;
          else if (!ovr_o && (result_o < R_LO_V) && (range_sel_o != 5'd0))
            range_nxt = range_sel_o - 5'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    sel_nxt       = 4'b0000;
    afe_reset_nxt = 1'b0;
    ref_sign_nxt  = 1'b0;
    valid_nxt     = 1'b0;
    busy_nxt      = (state_nxt != S_IDLE);
    case (state_nxt)
      S_IDLE, S_WAIT_REF, S_RST: afe_reset_nxt = 1'b1;
      S_AZ:    sel_nxt = 4'b0001;
      S_INT:   sel_nxt = 4'b0010;
      S_DEINT: begin
        sel_nxt      = pol_nxt ? 4'b1000 : 4'b0100;
        ref_sign_nxt = pol_nxt;
      end
      S_DONE: begin
        afe_reset_nxt = 1'b1;
        valid_nxt     = 1'b1;
      end
      default: afe_reset_nxt = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      afe_sel_o   <= 4'b0000;
      afe_reset_o <= 1'b1;
      ref_sign_o  <= 1'b0;
      range_sel_o <= 5'd0;
      mode_sel_o  <= 3'd0;
      result_o    <= '0;
      sign_o      <= 1'b0;
      ovr_o       <= 1'b0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      afe_sel_o   <= sel_nxt;
      afe_reset_o <= afe_reset_nxt;
      ref_sign_o  <= ref_sign_nxt;
      range_sel_o <= range_nxt;
      mode_sel_o  <= mode_nxt;
      result_o    <= result_nxt;
      sign_o      <= sign_nxt;
      ovr_o       <= ovr_nxt;
      valid_o     <= valid_nxt;
      busy_o      <= busy_nxt;
    end
  end

endmodule
